// File: rtl/pc_seg.sv
// rtl/pc_seg.sv - segmented program counter with one-segment-per-clock carry/borrow ripple
// Low segment updates in the operation cycle; upper segments are fixed up on later clocks.
module pc_seg #(
    parameter int             AW        = 16,
    parameter int             DW        = 8,
    parameter logic [AW-1:0]  RESET_VEC = '0
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          WR,
    input  logic          INC,
    input  logic          BR,
    input  logic [DW-1:0] OFF,
    input  logic [AW-1:0] D,
    output logic [AW-1:0] PC,
    output logic          CO,
    output logic          BO,
    output logic          RDY,
    output logic          PX
);

    localparam int N  = AW / DW;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CARRY  = 2'd1,
        ST_BORROW = 2'd2
    } fix_state_e;

    fix_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [KW-1:0] k_q, k_d;
    logic          px_q, px_d;

    logic [DW-1:0] seg0;
    logic [DW-1:0] segk;
    logic [DW-1:0] segk_n;
    logic [DW:0]   sum;
    logic          wrap;

    always_comb begin
        seg0 = pc_q[DW-1:0];
        segk = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                segk = pc_q[i*DW +: DW];
            end
        end
        segk_n = (state_q == ST_CARRY) ? segk + 1'b1 : segk - 1'b1;
        // A segment wraps when the carry leaves it at all-zeros or the borrow at all-ones.
        wrap   = (state_q == ST_CARRY) ? (segk == '1) : (segk == '0);
        sum    = {1'b0, seg0} + {1'b0, OFF};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        px_d    = 1'b0;

        if (WR) begin
            pc_d    = D;
            state_d = ST_IDLE;
            k_d     = '0;
        end else if (state_q != ST_IDLE) begin
            for (int i = 1; i < N; i++) begin
                if (k_q == KW'(i)) begin
                    pc_d[i*DW +: DW] = segk_n;
                end
            end
            if (wrap && (k_q != KW'(N - 1))) begin
                k_d = k_q + 1'b1;
            end else begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        end else if (BR) begin
            pc_d[DW-1:0] = sum[DW-1:0];
            // Carry out with a negative offset cancels the sign extension; no fixup needed.
            if (N > 1) begin
                if (sum[DW] && !OFF[DW-1]) begin
                    state_d = ST_CARRY;
                    k_d     = KW'(1);
                    px_d    = 1'b1;
                end else if (!sum[DW] && OFF[DW-1]) begin
                    state_d = ST_BORROW;
                    k_d     = KW'(1);
                    px_d    = 1'b1;
                end
            end
        end else if (INC) begin
            pc_d[DW-1:0] = seg0 + 1'b1;
            if ((N > 1) && (seg0 == '1)) begin
                state_d = ST_CARRY;
                k_d     = KW'(1);
                px_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            pc_q    <= RESET_VEC;
            state_q <= ST_IDLE;
            k_q     <= '0;
            px_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            k_q     <= k_d;
            px_q    <= px_d;
        end
    end

    assign PC  = pc_q;
    assign CO  = (state_q == ST_CARRY);
    assign BO  = (state_q == ST_BORROW);
    assign RDY = (state_q == ST_IDLE);
    assign PX  = px_q;

endmodule

// File: tb/tb_pc_seg.sv
// tb/tb_pc_seg.sv - bench for pc_seg at AW=16, AW=24, AW=16 with reset vector, and AW=8 (N=1)
module tb_pc_seg;

    logic        CLK;
    logic        r, wr, inc, br;
    logic [7:0]  off;
    logic [23:0] d;

    logic [15:0] pc0, pc2;
    logic [23:0] pc1;
    logic [7:0]  pc3;
    logic [3:0]  co, bo, rdy, px;

    int errors = 0;
    int checks = 0;

    pc_seg #(.AW(16), .DW(8), .RESET_VEC(16'h0000)) u0 (
        .CLK(CLK), .R(r), .WR(wr), .INC(inc), .BR(br), .OFF(off), .D(d[15:0]),
        .PC(pc0), .CO(co[0]), .BO(bo[0]), .RDY(rdy[0]), .PX(px[0]));
    pc_seg #(.AW(24), .DW(8), .RESET_VEC(24'h000000)) u1 (
        .CLK(CLK), .R(r), .WR(wr), .INC(inc), .BR(br), .OFF(off), .D(d),
        .PC(pc1), .CO(co[1]), .BO(bo[1]), .RDY(rdy[1]), .PX(px[1]));
    pc_seg #(.AW(16), .DW(8), .RESET_VEC(16'hFFFC)) u2 (
        .CLK(CLK), .R(r), .WR(wr), .INC(inc), .BR(br), .OFF(off), .D(d[15:0]),
        .PC(pc2), .CO(co[2]), .BO(bo[2]), .RDY(rdy[2]), .PX(px[2]));
    pc_seg #(.AW(8), .DW(8), .RESET_VEC(8'h00)) u3 (
        .CLK(CLK), .R(r), .WR(wr), .INC(inc), .BR(br), .OFF(off), .D(d[7:0]),
        .PC(pc3), .CO(co[3]), .BO(bo[3]), .RDY(rdy[3]), .PX(px[3]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each op computes the final address arithmetically; the visible PC takes the
    // low segment at once and one more upper segment of the final value per fixup cycle.
    int     aw_t[4] = '{16, 24, 16, 8};
    longint rv_t[4] = '{64'h0, 64'h0, 64'hFFFC, 64'h0};
    longint mpc[4], mfin[4];
    int     rem[4], nseg[4];
    bit     up[4], mpx[4];
    bit     armed = 1'b0;

    task automatic model_step(input int i);
        longint mask, delta, segm;
        int     m;
        mask   = (64'd1 << aw_t[i]) - 1;
        mpx[i] = 1'b0;
        if (r) begin
            mpc[i] = rv_t[i];
            rem[i] = 0;
        end else if (wr) begin
            mpc[i] = longint'(d) & mask;
            rem[i] = 0;
        end else if (rem[i] > 0) begin
            segm    = 64'hFF << (8 * nseg[i]);
            mpc[i]  = (mpc[i] & ~segm) | (mfin[i] & segm);
            nseg[i] = nseg[i] + 1;
            rem[i]  = rem[i] - 1;
        end else if (br || inc) begin
            delta   = br ? longint'($signed(off)) : 64'sd1;
            mfin[i] = (mpc[i] + delta) & mask;
            m = 0;
            for (int s = 1; s < aw_t[i] / 8; s++) begin
                if ((((mpc[i] ^ mfin[i]) >> (8 * s)) & 64'hFF) != 0) m = s;
            end
            mpc[i]  = (mpc[i] & ~64'hFF) | (mfin[i] & 64'hFF);
            rem[i]  = m;
            nseg[i] = 1;
            up[i]   = (delta > 0);
            mpx[i]  = (m > 0);
        end
    endtask

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) model_step(i);
        if (r) armed = 1'b1;
    end

    function automatic logic [63:0] dut_pc(input int i);
        case (i)
            0:       return {48'd0, pc0};
            1:       return {40'd0, pc1};
            2:       return {48'd0, pc2};
            default: return {56'd0, pc3};
        endcase
    endfunction

    always @(negedge CLK) begin
        if (armed) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d_pc", i),  dut_pc(i), mpc[i]);
                chk($sformatf("u%0d_co", i),  {63'd0, co[i]},  {63'd0, (rem[i] > 0) && up[i]});
                chk($sformatf("u%0d_bo", i),  {63'd0, bo[i]},  {63'd0, (rem[i] > 0) && !up[i]});
                chk($sformatf("u%0d_rdy", i), {63'd0, rdy[i]}, {63'd0, rem[i] == 0});
                chk($sformatf("u%0d_px", i),  {63'd0, px[i]},  {63'd0, mpx[i]});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    task automatic do_op(input bit w, input bit i, input bit b, input logic [7:0] o,
                         input logic [23:0] dd);
        wr = w; inc = i; br = b; off = o; d = dd;
        step();
        wr = 1'b0; inc = 1'b0; br = 1'b0;
    endtask

    task automatic settle(input string name);
        int n = 0;
        while (rdy !== 4'hF && n < 6) begin
            step();
            n++;
        end
        chk(name, {60'd0, rdy}, 64'hF);
    endtask

    logic [23:0] tab_d[6]   = '{24'h00FF80, 24'h010005, 24'hFFFFF0, 24'h000000, 24'h7FFF7F, 24'h01FF00};
    logic [7:0]  tab_off[6] = '{8'h90, 8'hF0, 8'h10, 8'hFF, 8'h01, 8'h80};

    initial begin
        r = 1'b0; wr = 1'b0; inc = 1'b0; br = 1'b0; off = '0; d = '0;
        step();
        do_op(1, 0, 0, 8'h00, 24'hABCDEF);
        r = 1'b1; step(); r = 1'b0;
        chk("rst_pc", {48'd0, pc0}, 64'h0000);
        chk("rst_vec", {48'd0, pc2}, 64'hFFFC);
        chk("rst_flags", {60'd0, co[0], bo[0], rdy[0], px[0]}, 64'b0010);

        do_op(1, 0, 0, 8'h00, 24'h0012FF);
        do_op(0, 1, 0, 8'h00, 24'h0);
        chk("inc_cross_pc", {48'd0, pc0}, 64'h1200);
        chk("inc_cross_flags", {60'd0, co[0], bo[0], rdy[0], px[0]}, 64'b1001);
        chk("n1_wrap", {56'd0, pc3, co[3]}, {56'd0, 8'h00, 1'b0});
        step();
        chk("inc_fix_pc", {48'd0, pc0}, 64'h1300);
        chk("inc_fix_rdy", {63'd0, rdy[0]}, 64'd1);

        do_op(1, 0, 0, 8'h00, 24'h001280);
        do_op(0, 0, 1, 8'h90, 24'h0);
        chk("br_nofix", {47'd0, pc0, rdy[0]}, {47'd0, 16'h1210, 1'b1});
        do_op(1, 0, 0, 8'h00, 24'h001205);
        do_op(0, 0, 1, 8'hF0, 24'h0);
        chk("br_back_pc", {48'd0, pc0}, 64'h12F5);
        chk("br_back_bo", {63'd0, bo[0]}, 64'd1);
        step();
        chk("br_back_fix", {48'd0, pc0}, 64'h11F5);
        do_op(1, 0, 0, 8'h00, 24'h0012F0);
        do_op(0, 0, 1, 8'h20, 24'h0);
        chk("br_fwd_pc", {48'd0, pc0}, 64'h1210);
        step();
        chk("br_fwd_fix", {48'd0, pc0}, 64'h1310);

        do_op(1, 0, 0, 8'h00, 24'h00FFFF);
        do_op(0, 1, 0, 8'h00, 24'h0);
        chk("wrap16_a", {48'd0, pc0}, 64'hFF00);
        chk("wrap24_a", {40'd0, pc1}, 64'h00FF00);
        step();
        chk("wrap16_b", {47'd0, pc0, co[0]}, {47'd0, 16'h0000, 1'b0});
        chk("wrap24_b", {39'd0, pc1, rdy[1]}, {39'd0, 24'h000000, 1'b0});
        step();
        chk("wrap24_c", {39'd0, pc1, rdy[1]}, {39'd0, 24'h010000, 1'b1});

        do_op(1, 0, 0, 8'h00, 24'h0012FF);
        do_op(0, 1, 0, 8'h00, 24'h0);
        do_op(0, 1, 0, 8'h00, 24'h0);
        chk("inc_during_fix", {48'd0, pc0}, 64'h1300);
        step();
        chk("inc_dropped", {48'd0, pc0}, 64'h1300);
        do_op(1, 0, 0, 8'h00, 24'h0012FF);
        do_op(0, 1, 0, 8'h00, 24'h0);
        do_op(1, 0, 0, 8'h00, 24'h004000);
        chk("wr_abort", {47'd0, pc0, co[0]}, {47'd0, 16'h4000, 1'b0});
        do_op(1, 1, 0, 8'h00, 24'h005555);
        chk("wr_inc_load", {48'd0, pc0}, 64'h5555);

        do_op(1, 0, 0, 8'h00, 24'h0012FF);
        do_op(0, 1, 0, 8'h00, 24'h0);
        r = 1'b1; step(); r = 1'b0;
        chk("rst_mid_fix", {47'd0, pc0, co[0]}, {47'd0, 16'h0000, 1'b0});
        chk("rst_mid_vec", {48'd0, pc2}, 64'hFFFC);
        step();
        chk("rst_no_update", {48'd0, pc0}, 64'h0000);

        for (int t = 0; t < 6; t++) begin
            do_op(1, 0, 0, 8'h00, tab_d[t]);
            do_op(0, 0, 1, tab_off[t], 24'h0);
            settle($sformatf("br_tab%0d_settle", t));
            do_op(0, 1, 0, 8'h00, 24'h0);
            settle($sformatf("inc_tab%0d_settle", t));
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
